// File: rtl/yrv_key_in_if.sv
// yrv_key_in_if: board key bundle between the key block and the MCU top.
// master drives raw keys and controls, slave returns debounced state.
interface yrv_key_in_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic              int_en;
  logic              flag_clr;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [15:0]       key_word;
  logic              int_req;

  modport master (
    output key_raw,
    output int_en,
    output flag_clr,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_word,
    input  int_req
  );

  modport slave (
    input  key_raw,
    input  int_en,
    input  flag_clr,
    output key_level,
    output key_press,
    output key_release,
    output key_word,
    output int_req
  );
endinterface

// File: rtl/yrv_key_in.sv
// yrv_key_in: synchronised, tick-debounced board keys with sticky
// press/release flags, a port4_in status word and a maskable irq.
module yrv_key_in #(
  parameter int N_KEYS         = 4,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int STABLE_SAMPLES = 4,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input logic        clk,
  input logic        resetb,
  yrv_key_in_if.slave bus
);
  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
  localparam logic [3:0] RUN_M1 = 4'(STABLE_SAMPLES - 1);

  logic [N_KEYS-1:0] w_raw;
  logic [N_KEYS-1:0] r_s1;
  logic [N_KEYS-1:0] r_s2;
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [N_KEYS-1:0] w_level_nxt;
  logic [N_KEYS-1:0] w_set_p;
  logic [N_KEYS-1:0] w_set_r;
  logic [3:0]        r_run [N_KEYS];
  logic [3:0]        w_run_nxt [N_KEYS];
  logic [DW-1:0]     r_div;
  logic              w_tick;
  logic              r_clr_q;
  logic              r_clr_prev;
  logic              w_clr;
  logic [3:0]        w_lvl4;
  logic [3:0]        w_prs4;
  logic [3:0]        w_rel4;

  assign w_raw  = KEY_ACTIVE_LOW ? ~bus.key_raw : bus.key_raw;
  assign w_tick = (r_div == DIV_M1);
  assign w_clr  = r_clr_q & ~r_clr_prev;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_div      <= '0;
      r_clr_q    <= 1'b0;
      r_clr_prev <= 1'b0;
    end else begin
      r_s1       <= w_raw;
      r_s2       <= r_s1;
      r_div      <= w_tick ? '0 : r_div + DW'(1);
      r_clr_q    <= bus.flag_clr;
      r_clr_prev <= r_clr_q;
    end
  end

  // any agreeing sample restarts the run, so bounces never accumulate
  always_comb begin
    w_level_nxt = r_level;
    w_set_p     = '0;
    w_set_r     = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_run_nxt[i] = r_run[i];
      if (w_tick) begin
        if (r_s2[i] == r_level[i]) begin
          w_run_nxt[i] = '0;
        end else if (r_run[i] == RUN_M1) begin
          w_run_nxt[i]   = '0;
          w_level_nxt[i] = r_s2[i];
          w_set_p[i]     = r_s2[i];
          w_set_r[i]     = ~r_s2[i];
        end else begin
          w_run_nxt[i] = r_run[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < N_KEYS; i++)
        r_run[i] <= '0;
    end else begin
      r_level   <= w_level_nxt;
      r_press   <= (r_press & ~{N_KEYS{w_clr}}) | w_set_p;
      r_release <= (r_release & ~{N_KEYS{w_clr}}) | w_set_r;
      for (int i = 0; i < N_KEYS; i++)
        r_run[i] <= w_run_nxt[i];
    end
  end

  assign w_lvl4 = 4'(r_level);
  assign w_prs4 = 4'(r_press);
  assign w_rel4 = 4'(r_release);

  assign bus.key_level   = r_level;
  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;
  assign bus.key_word    = {4'b0, w_rel4, w_prs4, w_lvl4};
  assign bus.int_req     = bus.int_en & |r_press;
endmodule
